instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   LEGv8 fetch stage directly upstream of the control unit. Holds the PC and fetches 32-bit words from
//   instruction memory over a req/ack handshake. Latches each word into an instruction register driving
//   instr. Advances the PC when the instruction retires, using PS from the control word and the K constant.
// PARAMETERS
//   PC_RESET  64'h0  PC value loaded on reset
//   PC_W      64     PC / address width
//   CNT_W     32     retired-instruction counter width
// PORTS
//   clock        in   1      system clock, all state on rising edge
//   reset        in   1      synchronous, active-high
//   ps           in   2      PC select from control word: 00 hold, 01 PC+4, 10 PC+(k<<2), 11 reg_target
//   k            in   PC_W   sign-extended branch offset in words, from the control unit
//   reg_target   in   PC_W   register-sourced target (BR)
//   instr_taken  in   1      datapath has executed the presented instruction this cycle
//   imem_req     out  1      fetch request
//   imem_addr    out  PC_W   fetch address (= pc while imem_req)
//   imem_ack     in   1      read data valid; may arrive 1..N cycles after req
//   imem_rdata   in   32     instruction word
//   instr        out  32     instruction register to the control unit
//   instr_valid  out  1      instr holds a fetched, not-yet-retired instruction
//   pc           out  PC_W   address of the current instruction
//   pc_plus4     out  PC_W   pc+4, link value for BL
//   misalign     out  1      sticky: a reg_target with [1:0]!=0 was taken
//   instr_count  out  CNT_W  retired-instruction count
// BEHAVIOUR
//   Reset (synchronous, overrides everything): state=BOOT; pc=PC_RESET; instr=32'h0; instr_valid=0;
//     imem_req=0; misalign=0; instr_count=0.
//   FSM states: BOOT, FETCH, ISSUE.
//     BOOT: imem_req=0 for exactly 1 cycle. Any imem_ack is ignored, which absorbs a stale ack
//       after a reset mid-fetch. Next state: FETCH.
//     FETCH: imem_req=1, imem_addr=pc, instr_valid=0. Remain in FETCH until imem_ack=1.
//       On imem_ack=1: instr<=imem_rdata, next state ISSUE. imem_req drops in the ISSUE cycle.
//     ISSUE: instr_valid=1, imem_req=0, instr stable. imem_ack is ignored.
//       On instr_taken=1: update pc per ps, instr_count+=1, next state FETCH.
//       While instr_taken=0: hold all state.
//   instr_taken outside ISSUE is ignored (no PC update, no count).
//   PC update (modulo 2^PC_W, wrap silently):
//     00 -> pc unchanged; the same address is refetched (halt loop).
//     01 -> pc+4.
//     10 -> pc + (k<<2), k treated as two's complement.
//     11 -> {reg_target[PC_W-1:2],2'b00}. If reg_target[1:0]!=0, set misalign.
//   misalign clears only on reset.
//   pc_plus4 = pc+4, combinational, wraps.
//   instr_count wraps from all-ones to 0.
//   Latency: ack in cycle N -> instr_valid=1 in cycle N+1. Taken in cycle M -> new imem_req in M+1.
//     Minimum 3 cycles per instruction with a 1-cycle memory.
//   Reset asserted in any state, including FETCH with an outstanding req or ISSUE with instr_taken=1:
//     reset wins. No PC update and no count that cycle.
// TESTING
//   1. Reset, PC_RESET=0, 1-cycle ack, ps=01 for 4 instrs: imem_addr 0,4,8,12;
//      instr_count=4; instr_valid high 1 cycle per instr.
//   2. Ack delayed 5 cycles: imem_req held 5 cycles, imem_addr stable, instr_valid=0 throughout;
//      instr = imem_rdata the cycle after ack.
//   3. pc=0x100, ps=10, k=-2 (64'hFFFF_FFFF_FFFF_FFFE) -> next imem_addr=0xF8;
//      pc=0x100, k=3 -> 0x10C.
//   4. ps=11, reg_target=0x2003 -> pc=0x2000, misalign=1 and stays 1 until reset;
//      ps=00 -> same address refetched.
//   5. pc=64'hFFFF_FFFF_FFFF_FFFC, ps=01 -> pc=0, pc_plus4 wraps to 0;
//      instr_count preset near all-ones wraps to 0.
//   6. Reset during FETCH with ack arriving in the BOOT cycle: ack ignored, instr_valid=0,
//      first fetch at PC_RESET returns the correct word; instr_taken while not ISSUE has no effect.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch stage holding the PC, fetching over req/ack into an instruction register
module instr_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       ps,
    input  logic [PC_W-1:0]  k,
    input  logic [PC_W-1:0]  reg_target,
    input  logic             instr_taken,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic             misalign,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [1:0] {BOOT, FETCH, ISSUE} state_t;
    state_t           r_state, w_next;
    logic [PC_W-1:0]  r_pc, w_pc_next, w_pc_plus4;
    logic [31:0]      r_instr;
    logic             r_misalign, w_retire;
    logic [CNT_W-1:0] r_count;
    always_ff @(posedge clock) begin
        if (reset) r_state <= BOOT;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == BOOT)  ? FETCH :
                 (r_state == FETCH) ? (imem_ack ? ISSUE : FETCH) :
                 (instr_taken ? FETCH : ISSUE);
    end
    assign w_retire   = (r_state == ISSUE) && instr_taken;
    assign w_pc_plus4 = r_pc + PC_W'(4);
    // k counts words, so the byte offset is k<<2; BR targets are forced word-aligned
    assign w_pc_next  = (ps == 2'b00) ? r_pc :
                        (ps == 2'b01) ? w_pc_plus4 :
                        (ps == 2'b10) ? r_pc + {k[PC_W-3:0], 2'b00} :
                                        {reg_target[PC_W-1:2], 2'b00};
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= PC_RESET;
            r_instr    <= 32'h0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            if (r_state == FETCH && imem_ack) r_instr <= imem_rdata;
            if (w_retire) begin
                r_pc    <= w_pc_next;
                r_count <= r_count + CNT_W'(1);
                if (ps == 2'b11 && |reg_target[1:0]) r_misalign <= 1'b1;
            end
        end
    end
    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == ISSUE);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misalign    = r_misalign;
    assign instr_count = r_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table plus scoreboard of expected fetch addresses, with reset corner sequences
module tb_instr_fetch_unit;
    logic        clock, reset, instr_taken, imem_ack;
    logic [1:0]  ps;
    logic [63:0] k, reg_target;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, misalign;
    logic [63:0] imem_addr, pc, pc_plus4;
    logic [31:0] instr, instr_count;
    logic        req2, valid2, mis2;
    logic [63:0] addr2, pc2, pc_plus4_2;
    logic [31:0] instr2;
    logic [1:0]  cnt2;

    instr_fetch_unit dut (
        .clock(clock), .reset(reset), .ps(ps), .k(k), .reg_target(reg_target),
        .instr_taken(instr_taken), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .misalign(misalign), .instr_count(instr_count)
    );

    // second instance with a tiny counter and a top-of-space reset PC, run in lockstep
    instr_fetch_unit #(.PC_W(64), .PC_RESET(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .ps(ps), .k(k), .reg_target(reg_target),
        .instr_taken(instr_taken), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr2),
        .instr_valid(valid2), .pc(pc2), .pc_plus4(pc_plus4_2),
        .misalign(mis2), .instr_count(cnt2)
    );

    typedef struct {
        logic [1:0]  ps;
        logic [63:0] k;
        logic [63:0] rt;
        int          dly;
        logic [63:0] nxt;
        logic        mis;
    } vec_t;

    vec_t        tbl[14];
    logic [63:0] sb[$];
    int          total = 0;
    int          bad = 0;
    int          exp_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_instr(input vec_t v, input bit hold);
        logic [63:0] a;
        logic [31:0] w;
        int n;
        a = sb.pop_front();
        w = word(a);
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_timeout", 64'(n < 20), 64'd1);
        chk("fetch_addr", imem_addr, a);
        for (int j = 0; j < v.dly; j++) begin
            instr_taken = 1'b1;
            ps = 2'b01;
            @(negedge clock);
            chk("req_held", 64'(imem_req), 64'd1);
            chk("addr_stable", imem_addr, a);
            chk("valid_low_wait", 64'(instr_valid), 64'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = w;
        instr_taken = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        instr_taken = 1'b0;
        chk("valid_issue", 64'(instr_valid), 64'd1);
        chk("req_drop", 64'(imem_req), 64'd0);
        chk("instr", 64'(instr), 64'(w));
        chk("pc", pc, a);
        chk("pc_plus4", pc_plus4, a + 64'd4);
        chk("count_pre", 64'(instr_count), 64'(exp_cnt));
        if (hold) begin
            imem_ack = 1'b1;
            imem_rdata = ~w;
            @(negedge clock);
            imem_ack = 1'b0;
            chk("hold_valid", 64'(instr_valid), 64'd1);
            chk("hold_instr", 64'(instr), 64'(w));
            chk("hold_pc", pc, a);
        end
        ps = v.ps;
        k = v.k;
        reg_target = v.rt;
        instr_taken = 1'b1;
        sb.push_back(v.nxt);
        exp_cnt++;
        @(negedge clock);
        instr_taken = 1'b0;
        chk("misalign", 64'(misalign), 64'(v.mis));
        chk("count_post", 64'(instr_count), 64'(exp_cnt));
        chk("count2_wrap", 64'(cnt2), 64'(exp_cnt & 3));
        chk("valid_after", 64'(instr_valid), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{2'b01, 64'd0, 64'd0, 0, 64'h4, 1'b0};
        tbl[1]  = '{2'b01, 64'd0, 64'd0, 0, 64'h8, 1'b0};
        tbl[2]  = '{2'b01, 64'd0, 64'd0, 0, 64'hC, 1'b0};
        tbl[3]  = '{2'b01, 64'd0, 64'd0, 4, 64'h10, 1'b0};
        tbl[4]  = '{2'b11, 64'd0, 64'h100, 2, 64'h100, 1'b0};
        tbl[5]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 0, 64'hF8, 1'b0};
        tbl[6]  = '{2'b11, 64'd0, 64'h100, 3, 64'h100, 1'b0};
        tbl[7]  = '{2'b10, 64'd3, 64'd0, 0, 64'h10C, 1'b0};
        tbl[8]  = '{2'b00, 64'd0, 64'd0, 1, 64'h10C, 1'b0};
        tbl[9]  = '{2'b11, 64'd0, 64'h2003, 0, 64'h2000, 1'b1};
        tbl[10] = '{2'b01, 64'd0, 64'd0, 0, 64'h2004, 1'b1};
        tbl[11] = '{2'b11, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
        tbl[12] = '{2'b01, 64'd0, 64'd0, 1, 64'h0, 1'b1};
        tbl[13] = '{2'b10, 64'd1, 64'd0, 0, 64'h4, 1'b1};
        reset = 1'b1;
        instr_taken = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        ps = 2'b00;
        k = 64'd0;
        reg_target = 64'd0;
        repeat (2) @(negedge clock);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_count", 64'(instr_count), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        chk("rst_pc2", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("rst_pc_plus4_2", pc_plus4_2, 64'd0);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        chk("boot_req", 64'(imem_req), 64'd0);
        @(negedge clock);
        imem_ack = 1'b0;
        chk("boot_ack_ignored_valid", 64'(instr_valid), 64'd0);
        chk("boot_ack_ignored_instr", 64'(instr), 64'd0);
        sb.push_back(64'd0);
        for (int i = 0; i < 14; i++) begin
            do_instr(tbl[i], (i % 2) == 1);
            if (i == 0) chk("pc2_wrap", pc2, 64'd0);
        end

        // reset with a request outstanding, stale ack landing in the BOOT cycle
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        chk("rf_boot_req", 64'(imem_req), 64'd0);
        chk("rf_misalign_clr", 64'(misalign), 64'd0);
        chk("rf_pc", pc, 64'd0);
        chk("rf_count", 64'(instr_count), 64'd0);
        @(negedge clock);
        imem_ack = 1'b0;
        chk("rf_fetch_req", 64'(imem_req), 64'd1);
        chk("rf_valid", 64'(instr_valid), 64'd0);
        chk("rf_instr", 64'(instr), 64'd0);
        chk("rf_addr", imem_addr, 64'd0);
        sb.delete();
        sb.push_back(64'd0);
        exp_cnt = 0;
        do_instr(tbl[0], 1'b0);

        // reset wins over instr_taken in ISSUE
        imem_ack = 1'b1;
        imem_rdata = word(64'h4);
        @(negedge clock);
        imem_ack = 1'b0;
        chk("ri_valid", 64'(instr_valid), 64'd1);
        reset = 1'b1;
        instr_taken = 1'b1;
        ps = 2'b01;
        @(negedge clock);
        chk("ri_pc", pc, 64'd0);
        chk("ri_count", 64'(instr_count), 64'd0);
        chk("ri_valid_low", 64'(instr_valid), 64'd0);
        chk("ri_req_low", 64'(imem_req), 64'd0);
        reset = 1'b0;
        instr_taken = 1'b0;
        sb.delete();
        sb.push_back(64'd0);
        exp_cnt = 0;
        do_instr(tbl[0], 1'b1);
        do_instr(tbl[1], 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
